// File: rtl/sdrd_deserializer.sv
// ============================================================================
// Module   : sdrd_deserializer
// Purpose  : Assembles MSB-first serial SDRD bits into WIDTH-bit words, with
//            a readable holding register, sticky overrun and idle resync.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sdrd_deserializer #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       SSER,
    input  logic                       BA13,
    input  logic                       BA12,
    input  logic                       BR_W,
    input  logic                       SDRD,
    input  logic                       sdrd_en,
    output logic [WIDTH-1:0]           data,
    output logic                       data_valid,
    output logic                       overrun,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       busy
);

    localparam int             CW          = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  c_WIDTH     = CW'(WIDTH);
    localparam logic [7:0]     c_IDLE_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt;
    logic [WIDTH-1:0] r_data, w_data_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_overrun, w_overrun_nxt;
    logic [CW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]       r_idle, w_idle_nxt;

    logic w_sel, w_cap, w_rd, w_done;

    assign w_sel  = ~SSER & ~BA13 & BA12;
    assign w_cap  = w_sel & BR_W & sdrd_en;
    assign w_rd   = w_sel & ~BR_W;
    assign w_done = (r_state == ST_SHIFT) && (r_bit_cnt == c_WIDTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_bit_cnt <= '0;
            r_idle    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_overrun <= w_overrun_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_idle    <= w_idle_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_data_nxt    = r_data;
        w_valid_nxt   = r_valid;
        w_overrun_nxt = r_overrun;
        w_bit_cnt_nxt = r_bit_cnt;
        w_idle_nxt    = r_idle;

        // A read coinciding with word completion is absorbed by the completion.
        if (w_rd && !w_done) begin
            w_valid_nxt = 1'b0;
            if (!r_valid)
                w_overrun_nxt = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_cap) begin
                    w_shift_nxt   = {{(WIDTH-1){1'b0}}, SDRD};
                    w_bit_cnt_nxt = CW'(1);
                    w_idle_nxt    = '0;
                    w_state_nxt   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_done) begin
                    // Capture is not accepted in the completion cycle.
                    w_data_nxt    = r_shift;
                    w_valid_nxt   = 1'b1;
                    if (r_valid && !w_rd)
                        w_overrun_nxt = 1'b1;
                    w_bit_cnt_nxt = '0;
                    w_idle_nxt    = '0;
                    w_state_nxt   = ST_IDLE;
                end else if (w_cap) begin
                    w_shift_nxt   = {r_shift[WIDTH-2:0], SDRD};
                    w_bit_cnt_nxt = r_bit_cnt + CW'(1);
                    w_idle_nxt    = '0;
                end else if (r_idle == c_IDLE_LAST) begin
                    w_bit_cnt_nxt = '0;
                    w_idle_nxt    = '0;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_idle_nxt    = r_idle + 8'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign data       = r_data;
    assign data_valid = r_valid;
    assign overrun    = r_overrun;
    assign bit_cnt    = r_bit_cnt;
    assign busy       = (r_state == ST_SHIFT);

endmodule

`default_nettype wire

// File: tb/tb_sdrd_deserializer.sv
// ============================================================================
// Module   : tb_sdrd_deserializer
// Purpose  : Directed self-checking bench for sdrd_deserializer (WIDTH=8).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sdrd_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SSER = 1'b1;
    logic       BA13 = 1'b0;
    logic       BA12 = 1'b1;
    logic       BR_W = 1'b1;
    logic       SDRD = 1'b0;
    logic       sdrd_en = 1'b0;
    logic [7:0] data;
    logic       data_valid;
    logic       overrun;
    logic [3:0] bit_cnt;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    sdrd_deserializer #(.WIDTH(8), .TIMEOUT(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .SSER       (SSER),
        .BA13       (BA13),
        .BA12       (BA12),
        .BR_W       (BR_W),
        .SDRD       (SDRD),
        .sdrd_en    (sdrd_en),
        .data       (data),
        .data_valid (data_valid),
        .overrun    (overrun),
        .bit_cnt    (bit_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        SSER = 1'b1; BA13 = 1'b0; BA12 = 1'b1; BR_W = 1'b1; sdrd_en = 1'b0;
    endtask

    task automatic cap_bit(input logic b);
        SSER = 1'b0; BA13 = 1'b0; BA12 = 1'b1; BR_W = 1'b1; sdrd_en = 1'b1; SDRD = b;
        tick();
        bus_idle();
    endtask

    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 7; i > 7 - n; i--)
            cap_bit(w[i]);
    endtask

    task automatic rd_cycle();
        SSER = 1'b0; BA13 = 1'b0; BA12 = 1'b1; BR_W = 1'b0; sdrd_en = 1'b0;
        tick();
        bus_idle();
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [7:0] d, input logic v,
                               input logic o, input logic [3:0] bc, input logic b);
        check({tag, ".data"},    16'(data),       16'(d));
        check({tag, ".valid"},   16'(data_valid), 16'(v));
        check({tag, ".overrun"}, 16'(overrun),    16'(o));
        check({tag, ".bit_cnt"}, 16'(bit_cnt),    16'(bc));
        check({tag, ".busy"},    16'(busy),       16'(b));
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check_state("reset", 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);

        // 0xA5 with one-clock completion latency
        send_bits(8'hA5, 8);
        check_state("a5_last_bit", 8'h00, 1'b0, 1'b0, 4'd8, 1'b1);
        tick();
        check_state("a5_done", 8'hA5, 1'b1, 1'b0, 4'd0, 1'b0);

        // Overrun, then reads
        send_bits(8'h3C, 8);
        tick();
        check_state("3c_overrun", 8'h3C, 1'b1, 1'b1, 4'd0, 1'b0);
        rd_cycle();
        check_state("rd1", 8'h3C, 1'b0, 1'b1, 4'd0, 1'b0);
        rd_cycle();
        check_state("rd2", 8'h3C, 1'b0, 1'b0, 4'd0, 1'b0);

        // Timeout: idle clocks with selected-but-disabled capture still count
        send_bits(8'hB0, 5);
        check_state("partial5", 8'h3C, 1'b0, 1'b0, 4'd5, 1'b1);
        SSER = 1'b0; BA13 = 1'b0; BA12 = 1'b1; BR_W = 1'b1; sdrd_en = 1'b0;
        for (int i = 0; i < 63; i++) begin
            SDRD = ~SDRD;
            tick();
        end
        check_state("idle63", 8'h3C, 1'b0, 1'b0, 4'd5, 1'b1);
        SDRD = ~SDRD;
        tick();
        bus_idle();
        check_state("idle64", 8'h3C, 1'b0, 1'b0, 4'd0, 1'b0);
        send_bits(8'hFF, 8);
        tick();
        check_state("ff_done", 8'hFF, 1'b1, 1'b0, 4'd0, 1'b0);

        // Read coinciding with completion of 0x81
        send_bits(8'h81, 8);
        rd_cycle();
        check_state("81_rd_same", 8'h81, 1'b1, 1'b0, 4'd0, 1'b0);

        // Reset mid-word, with capture asserted on the reset clock
        send_bits(8'hF0, 4);
        check("pre_rst.bit_cnt", 16'(bit_cnt), 16'd4);
        SSER = 1'b0; BA13 = 1'b0; BA12 = 1'b1; BR_W = 1'b1; sdrd_en = 1'b1; SDRD = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_idle();
        check_state("mid_rst", 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
        send_bits(8'h5A, 8);
        tick();
        check_state("5a_done", 8'h5A, 1'b1, 1'b0, 4'd0, 1'b0);

        // Non-capturing decodes, idle and mid-word
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 4; k++) begin
                SSER = 1'b0; BA13 = 1'b0; BA12 = 1'b1; BR_W = 1'b1; sdrd_en = 1'b1;
                case (k)
                    0: SSER = 1'b1;
                    1: BA13 = 1'b1;
                    2: BA12 = 1'b0;
                    default: sdrd_en = 1'b0;
                endcase
                SDRD = ~SDRD;
                tick();
                SDRD = ~SDRD;
                tick();
                bus_idle();
                check("nocap.bit_cnt", 16'(bit_cnt), (pass == 0) ? 16'd0 : 16'd3);
                check("nocap.data", 16'(data), 16'h5A);
            end
            if (pass == 0)
                send_bits(8'hE0, 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
